// File: rtl/dispatcher_pkg.sv
// Shared types, sizes and helpers for the thread-issue dispatcher.
package dispatcher_pkg;

  localparam int unsigned NUM_TID  = 256;
  localparam int unsigned TID_W    = 8;
  localparam int unsigned NUM_REGS = 34;
  localparam int unsigned CNT_W    = 16;

  typedef logic [TID_W-1:0]    tid_t;
  typedef logic [NUM_REGS-1:0] reg_map_t;
  typedef logic [NUM_TID-1:0]  tid_mask_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } disp_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic tid_t lowest_set(input tid_mask_t v);
    tid_t idx;
    idx = '0;
    for (int i = int'(NUM_TID) - 1; i >= 0; i--) begin
      if (v[i]) idx = TID_W'(i);
    end
    return idx;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/tid_dispatcher_if.sv
// Launch, scoreboard and issue-port signals of the dispatcher.
interface tid_dispatcher_if;
  import dispatcher_pkg::*;

  logic      start;
  tid_mask_t start_tid_mask;
  reg_map_t  start_regs_map;
  logic      flush;
  reg_map_t  regs_map;
  tid_t      rd_tid;
  logic      rd_valid;
  logic      collision;
  tid_t      rsv_tid;
  logic      rsv_valid;
  logic      issue_valid;
  tid_t      issue_tid;
  logic      issue_ready;
  logic      busy;
  logic      done;
  cnt_t      issued_cnt;
  cnt_t      collide_cnt;

  // Environment side: launches blocks, answers checks, accepts issues.
  modport master (
    output start, start_tid_mask, start_regs_map, flush, collision, issue_ready,
    input  regs_map, rd_tid, rd_valid, rsv_tid, rsv_valid, issue_valid, issue_tid,
           busy, done, issued_cnt, collide_cnt
  );

  // Dispatcher side.
  modport slave (
    input  start, start_tid_mask, start_regs_map, flush, collision, issue_ready,
    output regs_map, rd_tid, rd_valid, rsv_tid, rsv_valid, issue_valid, issue_tid,
           busy, done, issued_cnt, collide_cnt
  );
endinterface

// File: rtl/rr_tid_picker.sv
// Rotating priority encoder: lowest pending TID at or above ptr, else wrap.
module rr_tid_picker
  import dispatcher_pkg::*;
(
  input  tid_mask_t pending_i,
  input  tid_t      ptr_i,
  output tid_t      cand_o,
  output logic      cand_valid_o
);

  tid_mask_t upper_c;

  // Split pending into the part at/after ptr and fall back to the full mask.
  always_comb begin
    upper_c      = pending_i & ({NUM_TID{1'b1}} << ptr_i);
    cand_o       = (|upper_c) ? lowest_set(upper_c) : lowest_set(pending_i);
    cand_valid_o = |pending_i;
  end

endmodule

// File: rtl/tid_dispatcher.sv
// Thread-issue stage: walks pending TIDs round-robin, checks each against
// the scoreboard and issues non-colliding ones, skipping colliders.
module tid_dispatcher
  import dispatcher_pkg::*;
(
  input  logic clk,
  input  logic rst,
  tid_dispatcher_if.slave bus
);

  disp_state_e state_q, state_d;
  tid_mask_t   pending_q, pending_d;
  tid_t        ptr_q, ptr_d;
  reg_map_t    regs_map_q, regs_map_d;
  cnt_t        issued_q, issued_d;
  cnt_t        collide_q, collide_d;

  tid_t        cand_c;
  logic        cand_valid_c;
  logic        rd_valid_c;
  logic        issue_valid_c;
  logic        rsv_valid_c;

  rr_tid_picker u_picker (
    .pending_i    (pending_q),
    .ptr_i        (ptr_q),
    .cand_o       (cand_c),
    .cand_valid_o (cand_valid_c)
  );

  // Same-cycle check/issue handshake; flush suppresses any issue.
  always_comb begin
    rd_valid_c    = (state_q == SCAN) & cand_valid_c;
    issue_valid_c = rd_valid_c & ~bus.collision & ~bus.flush;
    rsv_valid_c   = issue_valid_c & bus.issue_ready;
  end

  assign bus.rd_valid    = rd_valid_c;
  assign bus.rd_tid      = cand_c;
  assign bus.rsv_tid     = cand_c;
  assign bus.issue_tid   = cand_c;
  assign bus.issue_valid = issue_valid_c;
  assign bus.rsv_valid   = rsv_valid_c;
  assign bus.regs_map    = regs_map_q;
  assign bus.busy        = (state_q == SCAN);
  assign bus.done        = (state_q == DONE);
  assign bus.issued_cnt  = issued_q;
  assign bus.collide_cnt = collide_q;

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    ptr_d      = ptr_q;
    regs_map_d = regs_map_q;
    issued_d   = issued_q;
    collide_d  = collide_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pending_d  = bus.start_tid_mask;
          regs_map_d = bus.start_regs_map;
          ptr_d      = '0;
          issued_d   = '0;
          collide_d  = '0;
          state_d    = (bus.start_tid_mask == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (rsv_valid_c) begin
          pending_d[cand_c] = 1'b0;
          ptr_d             = cand_c + TID_W'(1);
          issued_d          = sat_inc(issued_q);
        end else if (rd_valid_c && bus.collision) begin
          ptr_d     = cand_c + TID_W'(1);
          collide_d = sat_inc(collide_q);
        end
        if (pending_d == '0) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over launch, issue and completion.
    if (bus.flush) begin
      state_d   = IDLE;
      pending_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      ptr_q      <= '0;
      regs_map_q <= '0;
      issued_q   <= '0;
      collide_q  <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      regs_map_q <= regs_map_d;
      issued_q   <= issued_d;
      collide_q  <= collide_d;
    end
  end

endmodule

// File: tb/tb_tid_dispatcher.sv
// Directed table-driven bench for tid_dispatcher plus multi-cycle sequences.
module tb_tid_dispatcher;
  import dispatcher_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  localparam reg_map_t REGS_A = 34'h3_0000_0011;
  localparam reg_map_t REGS_B = 34'h1_8000_0F00;

  tid_dispatcher_if bus ();

  tid_dispatcher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic      start;
    tid_mask_t mask;
    logic      coll;
    logic      rdy;
    logic      e_rdv;
    int        e_tid;
    logic      e_iv;
    logic      e_rsv;
    logic      e_busy;
    logic      e_done;
    int        e_iss;
    int        e_col;
  } vec_t;

  vec_t vt[17];

  function automatic tid_mask_t mk(input int a, input int b, input int c);
    tid_mask_t m;
    m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    return m;
  endfunction

  function automatic vec_t v(input logic s, input tid_mask_t m, input logic c, input logic r,
                             input logic rdv, input int tid, input logic iv, input logic rsv,
                             input logic bsy, input logic dn, input int iss, input int col);
    vec_t x;
    x.start = s;  x.mask = m;    x.coll = c;   x.rdy = r;
    x.e_rdv = rdv; x.e_tid = tid; x.e_iv = iv;  x.e_rsv = rsv;
    x.e_busy = bsy; x.e_done = dn; x.e_iss = iss; x.e_col = col;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input tid_mask_t m, input reg_map_t r,
                       input logic c, input logic rd, input logic f);
    bus.start = s; bus.start_tid_mask = m; bus.start_regs_map = r;
    bus.collision = c; bus.issue_ready = rd; bus.flush = f;
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Basic launch {3,7,200}
    vt[0]  = v(1, mk(3, 7, 200), 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
    vt[1]  = v(0, '0,            0, 1, 1, 3,   1, 1, 1, 0, 0, 0);
    vt[2]  = v(0, '0,            0, 1, 1, 7,   1, 1, 1, 0, 1, 0);
    vt[3]  = v(0, '0,            0, 1, 1, 200, 1, 1, 1, 0, 2, 0);
    vt[4]  = v(0, '0,            0, 1, 0, 0,   0, 0, 0, 1, 3, 0);
    vt[5]  = v(0, '0,            0, 1, 0, 0,   0, 0, 0, 0, 3, 0);
    // Collision skip {1,2}
    vt[6]  = v(1, mk(1, 2, -1),  0, 1, 0, 0,   0, 0, 0, 0, 3, 0);
    vt[7]  = v(0, '0,            1, 1, 1, 1,   0, 0, 1, 0, 0, 0);
    vt[8]  = v(0, '0,            0, 1, 1, 2,   1, 1, 1, 0, 0, 1);
    vt[9]  = v(0, '0,            0, 1, 1, 1,   1, 1, 1, 0, 1, 1);
    vt[10] = v(0, '0,            0, 1, 0, 0,   0, 0, 0, 1, 2, 1);
    // Wrap-around {0,255}
    vt[11] = v(1, mk(0, 255, -1), 0, 1, 0, 0,  0, 0, 0, 0, 2, 1);
    vt[12] = v(0, '0,            1, 1, 1, 0,   0, 0, 1, 0, 0, 0);
    vt[13] = v(0, '0,            0, 1, 1, 255, 1, 1, 1, 0, 0, 1);
    vt[14] = v(0, '0,            0, 1, 1, 0,   1, 1, 1, 0, 1, 1);
    vt[15] = v(0, '0,            0, 1, 0, 0,   0, 0, 0, 1, 2, 1);
    vt[16] = v(0, '0,            0, 1, 0, 0,   0, 0, 0, 0, 2, 1);

    // Reset values
    #2;
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_tid",   64'(bus.rd_tid), 64'd0);
    chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
    chk("rst_rsv_valid", 64'(bus.rsv_valid), 64'd0);
    chk("rst_busy",     64'(bus.busy), 64'd0);
    chk("rst_done",     64'(bus.done), 64'd0);
    chk("rst_regs_map", 64'(bus.regs_map), 64'd0);
    chk("rst_issued",   64'(bus.issued_cnt), 64'd0);
    chk("rst_collide",  64'(bus.collide_cnt), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 17; i++) begin
      next_cyc();
      drive(vt[i].start, vt[i].mask, REGS_A, vt[i].coll, vt[i].rdy, 1'b0);
      #1;
      chk($sformatf("v%0d_rd_valid", i), 64'(bus.rd_valid), 64'(vt[i].e_rdv));
      if (vt[i].e_rdv) begin
        chk($sformatf("v%0d_rd_tid", i),    64'(bus.rd_tid),    64'(vt[i].e_tid));
        chk($sformatf("v%0d_issue_tid", i), 64'(bus.issue_tid), 64'(vt[i].e_tid));
        chk($sformatf("v%0d_rsv_tid", i),   64'(bus.rsv_tid),   64'(vt[i].e_tid));
      end
      chk($sformatf("v%0d_issue_valid", i), 64'(bus.issue_valid), 64'(vt[i].e_iv));
      chk($sformatf("v%0d_rsv_valid", i),   64'(bus.rsv_valid),   64'(vt[i].e_rsv));
      chk($sformatf("v%0d_busy", i),        64'(bus.busy),        64'(vt[i].e_busy));
      chk($sformatf("v%0d_done", i),        64'(bus.done),        64'(vt[i].e_done));
      chk($sformatf("v%0d_issued", i),      64'(bus.issued_cnt),  64'(vt[i].e_iss));
      chk($sformatf("v%0d_collide", i),     64'(bus.collide_cnt), 64'(vt[i].e_col));
    end
    chk("tbl_regs_map", 64'(bus.regs_map), 64'(REGS_A));

    // Backpressure on a single TID
    next_cyc();
    drive(1'b1, mk(5, -1, -1), REGS_B, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      next_cyc();
      drive(1'b0, '0, '0, 1'b0, (k == 4), 1'b0);
      #1;
      if (k == 0) chk("bp_regs_map", 64'(bus.regs_map), 64'(REGS_B));
      chk($sformatf("bp%0d_rd_valid", k), 64'(bus.rd_valid), 64'd1);
      chk($sformatf("bp%0d_rd_tid", k),   64'(bus.rd_tid), 64'd5);
      chk($sformatf("bp%0d_issue_valid", k), 64'(bus.issue_valid), 64'd1);
      chk($sformatf("bp%0d_rsv_valid", k), 64'(bus.rsv_valid), 64'(k == 4));
    end
    next_cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("bp_ptr", 64'(dut.ptr_q), 64'd6);
    chk("bp_done", 64'(bus.done), 64'd1);
    chk("bp_issued", 64'(bus.issued_cnt), 64'd1);

    // Empty mask: straight to done, never a check
    next_cyc();
    drive(1'b1, '0, REGS_A, 1'b0, 1'b1, 1'b0);
    #1;
    chk("empty_c0_rd_valid", 64'(bus.rd_valid), 64'd0);
    next_cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("empty_c1_done", 64'(bus.done), 64'd1);
    chk("empty_c1_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("empty_c1_busy", 64'(bus.busy), 64'd0);
    next_cyc();
    #1;
    chk("empty_c2_done", 64'(bus.done), 64'd0);
    chk("empty_c2_rd_valid", 64'(bus.rd_valid), 64'd0);

    // Start ignored during SCAN, then flush mid-block
    next_cyc();
    drive(1'b1, mk(10, 20, -1), REGS_A, 1'b0, 1'b1, 1'b0);
    next_cyc();
    drive(1'b1, mk(30, -1, -1), REGS_B, 1'b1, 1'b1, 1'b0);
    #1;
    chk("ign_b_rd_tid", 64'(bus.rd_tid), 64'd10);
    chk("ign_b_issue_valid", 64'(bus.issue_valid), 64'd0);
    next_cyc();
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("ign_c_rd_tid", 64'(bus.rd_tid), 64'd20);
    chk("ign_c_pending", 64'(dut.pending_q == mk(10, 20, -1)), 64'd1);
    chk("ign_c_regs_map", 64'(bus.regs_map), 64'(REGS_A));
    next_cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("fl_d_rd_tid", 64'(bus.rd_tid), 64'd10);
    chk("fl_d_issue_valid", 64'(bus.issue_valid), 64'd0);
    chk("fl_d_rsv_valid", 64'(bus.rsv_valid), 64'd0);
    next_cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("fl_e_busy", 64'(bus.busy), 64'd0);
    chk("fl_e_done", 64'(bus.done), 64'd0);
    chk("fl_e_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("fl_e_collide", 64'(bus.collide_cnt), 64'd2);
    chk("fl_e_issued", 64'(bus.issued_cnt), 64'd0);
    next_cyc();
    #1;
    chk("fl_f_done", 64'(bus.done), 64'd0);

    // Asynchronous reset in the middle of a block
    next_cyc();
    drive(1'b1, mk(1, 2, 3), REGS_B, 1'b0, 1'b1, 1'b0);
    next_cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("mr_rsv_valid", 64'(bus.rsv_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("mr_busy", 64'(bus.busy), 64'd0);
    chk("mr_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("mr_regs_map", 64'(bus.regs_map), 64'd0);
    chk("mr_pending", 64'(dut.pending_q == '0), 64'd1);
    #1 rst = 1'b0;
    next_cyc();
    #1;
    chk("mr_after_busy", 64'(bus.busy), 64'd0);
    chk("mr_after_issued", 64'(bus.issued_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
